// File: rtl/aud_recorder_multi_if.sv
// Signal bundle between an I2S source/controller and aud_recorder_multi.
interface aud_recorder_multi_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20
);
  logic              i_lrc;
  logic              i_data;
  logic              i_start;
  logic              i_pause;
  logic              i_stop;
  logic [1:0]        i_mode;
  logic [ADDR_W-1:0] o_address;
  logic [DATA_W-1:0] o_data;
  logic              o_chan;
  logic              o_valid;
  logic              o_busy;
  logic              o_full;

  // Controller / codec side: drives the serial stream and control pulses.
  modport master (
    output i_lrc, i_data, i_start, i_pause, i_stop, i_mode,
    input  o_address, o_data, o_chan, o_valid, o_busy, o_full
  );

  // Recorder side.
  modport slave (
    input  i_lrc, i_data, i_start, i_pause, i_stop, i_mode,
    output o_address, o_data, o_chan, o_valid, o_busy, o_full
  );
endinterface

// File: rtl/aud_recorder_multi.sv
// I2S recorder: deserialises left/right/stereo samples from the codec bit
// clock and emits one addressed write per captured sample, with
// start/pause/resume/stop control and an automatic stop at MAX_ADDR.
module aud_recorder_multi #(
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 20,
  parameter int unsigned MAX_ADDR = 2**20 - 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  aud_recorder_multi_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SKIP,
    ST_SHIFT,
    ST_PAUSED,
    ST_DONE
  } state_t;

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] MAX_A    = ADDR_W'(MAX_ADDR);

  state_t              state_reg, state_next;
  logic                lrc_q;
  // Only the first DATA_W-1 bits need storing; the LSB comes straight
  // from the wire on the completing edge.
  logic [DATA_W-2:0]   shift_reg, shift_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic [1:0]          mode_reg, mode_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic                chan_reg, chan_next;
  logic                valid_reg, valid_next;

  logic                lrc_edge;
  logic                chan_sel;
  logic                capture_start;
  logic                limit_hit;
  logic [DATA_W-1:0]   word_in;

  // An edge is a word-select change; the channel being entered is i_lrc.
  assign lrc_edge      = bus.i_lrc != lrc_q;
  assign chan_sel      = (mode_reg == 2'd2) ? 1'b1 :
                         (mode_reg == 2'd1) ? bus.i_lrc : ~bus.i_lrc;
  assign capture_start = lrc_edge && chan_sel;
  assign word_in       = {shift_reg, bus.i_data};

  // Next-state and datapath decisions; stop beats the address limit, which
  // beats pause, which beats start.
  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    count_next = count_reg;
    mode_next  = mode_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    chan_next  = chan_reg;
    valid_next = 1'b0;
    limit_hit  = 1'b0;

    // The cycle after a write strobe moves the address on, unless that
    // write used the last slot, in which case recording ends there.
    if (valid_reg) begin
      if (addr_reg == MAX_A) begin
        limit_hit = 1'b1;
      end else begin
        addr_next = addr_reg + 1'b1;
      end
    end

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (bus.i_start) begin
          state_next = ST_WAIT;
          mode_next  = bus.i_mode;
          addr_next  = '0;
        end
      end
      ST_PAUSED: begin
        if (bus.i_start) begin
          state_next = ST_WAIT;
          mode_next  = bus.i_mode;
        end
      end
      ST_WAIT: begin
        if (bus.i_pause) begin
          state_next = ST_PAUSED;
        end else if (capture_start) begin
          // This edge is the I2S delay slot; the MSB arrives next cycle.
          state_next = ST_SKIP;
          count_next = '0;
        end
      end
      ST_SKIP: begin
        if (lrc_edge) begin
          state_next = capture_start ? ST_SKIP : ST_WAIT;
          count_next = '0;
        end else begin
          shift_next = word_in[DATA_W-2:0];
          count_next = CNT_W'(1);
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.i_pause) begin
          state_next = ST_PAUSED;
          count_next = '0;
        end else if (count_reg == LAST_BIT) begin
          // LSB sampled: publish the word tagged with the channel it was
          // captured in, and re-arm immediately if a new frame starts now.
          data_next  = word_in;
          chan_next  = lrc_q;
          valid_next = 1'b1;
          state_next = capture_start ? ST_SKIP : ST_WAIT;
          count_next = '0;
        end else if (lrc_edge) begin
          // Short frame: drop the partial word and treat as a fresh edge.
          state_next = capture_start ? ST_SKIP : ST_WAIT;
          count_next = '0;
        end else begin
          shift_next = word_in[DATA_W-2:0];
          count_next = count_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (limit_hit) begin
      state_next = ST_DONE;
      valid_next = 1'b0;
    end

    if (bus.i_stop) begin
      state_next = ST_IDLE;
      addr_next  = addr_reg;
      valid_next = 1'b0;
      count_next = '0;
    end
  end

  // State and datapath registers; reset throws away any partial sample.
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      state_reg <= ST_IDLE;
      lrc_q     <= 1'b0;
      shift_reg <= '0;
      count_reg <= '0;
      mode_reg  <= 2'd0;
      addr_reg  <= '0;
      data_reg  <= '0;
      chan_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      lrc_q     <= bus.i_lrc;
      shift_reg <= shift_next;
      count_reg <= count_next;
      mode_reg  <= mode_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      chan_reg  <= chan_next;
      valid_reg <= valid_next;
    end
  end

  assign bus.o_address = addr_reg;
  assign bus.o_data    = data_reg;
  assign bus.o_chan    = chan_reg;
  assign bus.o_valid   = valid_reg;
  assign bus.o_busy    = (state_reg == ST_WAIT) || (state_reg == ST_SKIP) ||
                         (state_reg == ST_SHIFT);
  assign bus.o_full    = (state_reg == ST_DONE);

endmodule

// File: doc/aud_recorder_multi.md
Name: aud_recorder_multi

Overview:
- Parametrised successor to the single-channel I2S audio recorder.
- Deserialises I2S serial data clocked by the codec bit clock into DATA_W-bit samples.
- Selects left, right or interleaved stereo capture; emits one write per sample (address, data, channel tag) towards the SRAM writer.
- Supports start/pause/resume/stop and stops automatically at a programmable address limit.

Parameters:
- DATA_W, 16, sample width in bits (MSB first on the wire); legal range 8..32.
- ADDR_W, 20, width of o_address.
- MAX_ADDR, 2**20-1, last writable address; reaching it ends recording.

Ports:
- i_clk  in  1  codec bit clock (BCLK); all logic on posedge.
- i_rst_n  in  1  asynchronous, active-high reset (name kept per codebase; asserted = 1).
- i_lrc  in  1  I2S word select: 0 = left, 1 = right; changes on BCLK negedge.
- i_data  in  1  I2S serial data, changes on BCLK negedge.
- i_start  in  1  one-cycle pulse: start from IDLE/DONE, or resume from PAUSED.
- i_pause  in  1  one-cycle pulse: pause while recording.
- i_stop  in  1  one-cycle pulse: abort to IDLE.
- i_mode  in  2  0 = left only, 1 = right only, 2 = stereo interleaved (L then R), 3 = treated as 0; sampled on start/resume only.
- o_address  out  ADDR_W  address of the current/last written sample.
- o_data  out  DATA_W  last completed sample.
- o_chan  out  1  channel of o_data (0 = L, 1 = R).
- o_valid  out  1  one-cycle write strobe.
- o_busy  out  1  high in WAIT/SKIP/SHIFT.
- o_full  out  1  high in DONE (limit reached).

Behaviour:
- Reset (async, i_rst_n = 1): state = IDLE; o_address = 0; o_data = 0; o_chan = 0; o_valid = 0; o_busy = 0; o_full = 0; shift register, bit counter and lrc_q cleared. Reset mid-sample discards the partial sample.
- Edge detect: lrc_q <= i_lrc each posedge. An edge is a posedge where i_lrc != lrc_q.
- Selected channel: matches mode (L for mode 0/3, R for mode 1, either for mode 2).
- States:
  - IDLE: i_start -> WAIT; o_address <= 0; mode latched.
  - WAIT: lrc edge into a selected channel -> SKIP. This edge posedge is the I2S one-bit delay slot and is not captured.
  - SKIP (transient): the next DATA_W posedges shift i_data in MSB first -> SHIFT.
  - SHIFT: bit counter counts 0..DATA_W-1.
    - On the posedge sampling the LSB: o_data <= completed word; o_chan <= lrc_q; o_valid = 1 for the following cycle. State -> WAIT.
    - An lrc edge before DATA_W bits are captured discards the partial word and is handled as a WAIT edge (restart capture if the new channel is selected).
    - Bits after the LSB within a frame are ignored.
  - Address update: first write uses address 0. o_address increments by 1 on the posedge after each o_valid, except the write at MAX_ADDR. That write goes to DONE with o_full = 1 and o_address held at MAX_ADDR.
  - PAUSED: entered on i_pause from WAIT/SHIFT; partial word discarded, address held, o_busy = 0. i_start -> WAIT; capture resumes at the next selected-channel edge; o_address continues, no duplicate address.
  - DONE: o_full = 1; i_start -> WAIT with o_address <= 0, o_full <= 0.
- i_stop in any state -> IDLE: partial word discarded, o_address/o_data hold last values, o_full <= 0.
- Simultaneous pulses: stop > pause > start. i_start while busy is ignored; i_pause outside WAIT/SHIFT is ignored.
- Stereo mode: L and R samples take consecutive addresses, o_chan distinguishes them.
- o_valid never asserts in IDLE/PAUSED/DONE; at most one o_valid per lrc half-frame.

Test Plan:
- Mode 0, DATA_W = 16, L frame = 16'hF2CF, R frame = 16'hF64F -> one o_valid, o_data = 16'hF2CF, o_chan = 0, o_address = 0; the R frame produces no write.
- Mode 2, frames L = 16'h83C1, R = 16'h9C58, L = 16'h6A4C -> writes at addresses 0, 1, 2 with data 83C1/9C58/6A4C, o_chan = 0/1/0, each o_valid exactly 1 cycle.
- Pause pulse at bit 5 of L word 16'hF2CF, then i_start -> the partial word is not written; the next complete L frame 16'hF64F is written at address 1 (after a prior write at 0).
- MAX_ADDR = 3, mode 0, 5 L frames -> writes at 0..3, o_full = 1 after the 4th write, o_address = 3, no 5th o_valid; i_start -> o_full = 0, o_address = 0.
- Stop and pause asserted together mid-SHIFT -> IDLE, o_busy = 0, no o_valid. Async reset pulsed mid-word (not on a clock edge) -> all outputs 0 immediately.
- lrc toggled after 10 bits (short frame) in mode 2 -> no write for the truncated channel; the following full 16-bit frame is captured correctly.
